// File: rtl/dram_cmd_fsm.sv
// DRAM command generator: turns one decoded request at a time into a
// PRE/ACT/RD/WR sequence. It tracks the open row of every bank, enforces
// tRP/tRCD/tCCD spacing and services refresh as PREA -> REF -> tRFC wait.
`timescale 1ns/1ps
module dram_cmd_fsm #(
  parameter int RANK_BITS       = 1,
  parameter int BANK_GROUP_BITS = 2,
  parameter int BANK_BITS       = 2,
  parameter int ROW_BITS        = 16,
  parameter int COLUMN_BITS     = 10,
  parameter int T_RP            = 4,
  parameter int T_RCD           = 4,
  parameter int T_CCD           = 2,
  parameter int T_RFC           = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [RANK_BITS-1:0]       req_rank,
  input  logic [BANK_GROUP_BITS-1:0] req_bg,
  input  logic [BANK_BITS-1:0]       req_bank,
  input  logic [ROW_BITS-1:0]        req_row,
  input  logic [COLUMN_BITS-1:0]     req_col,
  input  logic                       ref_req,
  output logic                       ref_ack,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd,
  output logic [RANK_BITS-1:0]       cmd_rank,
  output logic [BANK_GROUP_BITS-1:0] cmd_bg,
  output logic [BANK_BITS-1:0]       cmd_bank,
  output logic [ROW_BITS-1:0]        cmd_row,
  output logic [COLUMN_BITS-1:0]     cmd_col
);

  localparam int IDX_W = RANK_BITS + BANK_GROUP_BITS + BANK_BITS;
  localparam int NBANK = 1 << IDX_W;

  localparam logic [7:0] RP_CNT  = 8'(T_RP - 1);
  localparam logic [7:0] RCD_CNT = 8'(T_RCD - 1);
  localparam logic [7:0] CCD_CNT = 8'(T_CCD - 1);
  localparam logic [7:0] RFC_CNT = 8'(T_RFC - 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_ISSUE, S_WAIT_CCD,
    S_REF_PREA, S_REF_WAIT_RP, S_REF, S_REF_WAIT_RFC
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [NBANK-1:0]           open_q, open_d;
  logic [ROW_BITS-1:0]        row_tbl [NBANK];
  logic [RANK_BITS-1:0]       last_rank_q, last_rank_d;

  logic                       hold_write_q, hold_write_d;
  logic [RANK_BITS-1:0]       hold_rank_q, hold_rank_d;
  logic [BANK_GROUP_BITS-1:0] hold_bg_q, hold_bg_d;
  logic [BANK_BITS-1:0]       hold_bank_q, hold_bank_d;
  logic [ROW_BITS-1:0]        hold_row_q, hold_row_d;
  logic [COLUMN_BITS-1:0]     hold_col_q, hold_col_d;

  logic                       cmd_valid_q, cmd_valid_d;
  logic [2:0]                 cmd_q, cmd_d;
  logic [RANK_BITS-1:0]       cmd_rank_q, cmd_rank_d;
  logic [BANK_GROUP_BITS-1:0] cmd_bg_q, cmd_bg_d;
  logic [BANK_BITS-1:0]       cmd_bank_q, cmd_bank_d;
  logic [ROW_BITS-1:0]        cmd_row_q, cmd_row_d;
  logic [COLUMN_BITS-1:0]     cmd_col_q, cmd_col_d;
  logic                       ref_ack_q, ref_ack_d;

  logic [IDX_W-1:0]           req_idx, hold_idx;

  assign req_idx   = {req_rank, req_bg, req_bank};
  assign hold_idx  = {hold_rank_q, hold_bg_q, hold_bank_q};
  assign req_ready = !RST && (state_q == S_IDLE) && !ref_req;

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_rank  = cmd_rank_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign ref_ack   = ref_ack_q;

  // Next-state, bank-table and registered-output computation; outputs are
  // decoded from the next state so each command appears in its own state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    open_d       = open_q;
    last_rank_d  = last_rank_q;
    hold_write_d = hold_write_q;
    hold_rank_d  = hold_rank_q;
    hold_bg_d    = hold_bg_q;
    hold_bank_d  = hold_bank_q;
    hold_row_d   = hold_row_q;
    hold_col_d   = hold_col_q;

    case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          state_d = S_REF_PREA;
        end else if (req_valid) begin
          hold_write_d = req_write;
          hold_rank_d  = req_rank;
          hold_bg_d    = req_bg;
          hold_bank_d  = req_bank;
          hold_row_d   = req_row;
          hold_col_d   = req_col;
          last_rank_d  = req_rank;
          if (!open_q[req_idx])                 state_d = S_ACT;
          else if (row_tbl[req_idx] == req_row) state_d = S_ISSUE;
          else                                  state_d = S_PRE;
        end
      end
      S_PRE: begin
        open_d[hold_idx] = 1'b0;
        if (T_RP == 1) state_d = S_ACT;
        else begin state_d = S_WAIT_RP; cnt_d = RP_CNT; end
      end
      S_WAIT_RP: begin
        if (cnt_q <= 8'd1) state_d = S_ACT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ACT: begin
        open_d[hold_idx] = 1'b1;
        if (T_RCD == 1) state_d = S_ISSUE;
        else begin state_d = S_WAIT_RCD; cnt_d = RCD_CNT; end
      end
      S_WAIT_RCD: begin
        if (cnt_q <= 8'd1) state_d = S_ISSUE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ISSUE: begin
        if (T_CCD == 1) state_d = S_IDLE;
        else begin state_d = S_WAIT_CCD; cnt_d = CCD_CNT; end
      end
      S_WAIT_CCD: begin
        if (cnt_q <= 8'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_REF_PREA: begin
        open_d = '0;
        if (T_RP == 1) state_d = S_REF;
        else begin state_d = S_REF_WAIT_RP; cnt_d = RP_CNT; end
      end
      S_REF_WAIT_RP: begin
        if (cnt_q <= 8'd1) state_d = S_REF;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_REF: begin
        if (T_RFC == 1) state_d = S_IDLE;
        else begin state_d = S_REF_WAIT_RFC; cnt_d = RFC_CNT; end
      end
      S_REF_WAIT_RFC: begin
        if (cnt_q <= 8'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    cmd_rank_d  = '0;
    cmd_bg_d    = '0;
    cmd_bank_d  = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    case (state_d)
      S_PRE: begin
        cmd_valid_d = 1'b1; cmd_d = CMD_PRE;
        cmd_rank_d = hold_rank_d; cmd_bg_d = hold_bg_d; cmd_bank_d = hold_bank_d;
      end
      S_ACT: begin
        cmd_valid_d = 1'b1; cmd_d = CMD_ACT;
        cmd_rank_d = hold_rank_d; cmd_bg_d = hold_bg_d; cmd_bank_d = hold_bank_d;
        cmd_row_d  = hold_row_d;
      end
      S_ISSUE: begin
        cmd_valid_d = 1'b1; cmd_d = hold_write_d ? CMD_WR : CMD_RD;
        cmd_rank_d = hold_rank_d; cmd_bg_d = hold_bg_d; cmd_bank_d = hold_bank_d;
        cmd_col_d  = hold_col_d;
      end
      S_REF_PREA: begin
        cmd_valid_d = 1'b1; cmd_d = CMD_PREA; cmd_rank_d = last_rank_d;
      end
      S_REF: begin
        cmd_valid_d = 1'b1; cmd_d = CMD_REF; cmd_rank_d = last_rank_d;
      end
      default: ;
    endcase

    ref_ack_d = ((state_d == S_REF_WAIT_RFC) && (cnt_d == 8'd1)) ||
                ((state_d == S_REF) && (T_RFC == 1));
  end

  // Control state and registered command outputs, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      open_q      <= '0;
      last_rank_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_rank_q  <= '0;
      cmd_bg_q    <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      ref_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      last_rank_q <= last_rank_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_rank_q  <= cmd_rank_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      ref_ack_q   <= ref_ack_d;
    end
  end

  // Captured request and open-row table; only meaningful alongside the control state.
  always_ff @(posedge CLK) begin
    hold_write_q <= hold_write_d;
    hold_rank_q  <= hold_rank_d;
    hold_bg_q    <= hold_bg_d;
    hold_bank_q  <= hold_bank_d;
    hold_row_q   <= hold_row_d;
    hold_col_q   <= hold_col_d;
    if (!RST && state_q == S_ACT) row_tbl[hold_idx] <= hold_row_q;
  end

endmodule

// File: tb/tb_dram_cmd_fsm.sv
// Directed bench for dram_cmd_fsm: default timing instance plus a second
// instance with all spacings at 1 for the back-to-back corner.
`timescale 1ns/1ps
module tb_dram_cmd_fsm;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic        a_valid, a_ready, a_write, a_rank, a_ref_req, a_ref_ack, a_cmd_valid, a_cmd_rank;
  logic [1:0]  a_bg, a_bank, a_cmd_bg, a_cmd_bank;
  logic [15:0] a_row, a_cmd_row;
  logic [9:0]  a_col, a_cmd_col;
  logic [2:0]  a_cmd;

  logic        b_valid, b_ready, b_write, b_rank, b_ref_req, b_ref_ack, b_cmd_valid, b_cmd_rank;
  logic [1:0]  b_bg, b_bank, b_cmd_bg, b_cmd_bank;
  logic [15:0] b_row, b_cmd_row;
  logic [9:0]  b_col, b_cmd_col;
  logic [2:0]  b_cmd;

  dram_cmd_fsm u_dut_a (
    .CLK(CLK), .RST(RST), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_rank(a_rank), .req_bg(a_bg), .req_bank(a_bank), .req_row(a_row), .req_col(a_col),
    .ref_req(a_ref_req), .ref_ack(a_ref_ack), .cmd_valid(a_cmd_valid), .cmd(a_cmd),
    .cmd_rank(a_cmd_rank), .cmd_bg(a_cmd_bg), .cmd_bank(a_cmd_bank),
    .cmd_row(a_cmd_row), .cmd_col(a_cmd_col)
  );

  dram_cmd_fsm #(.T_RP(1), .T_RCD(1), .T_CCD(1)) u_dut_b (
    .CLK(CLK), .RST(RST), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_rank(b_rank), .req_bg(b_bg), .req_bank(b_bank), .req_row(b_row), .req_col(b_col),
    .ref_req(b_ref_req), .ref_ack(b_ref_ack), .cmd_valid(b_cmd_valid), .cmd(b_cmd),
    .cmd_rank(b_cmd_rank), .cmd_bg(b_cmd_bg), .cmd_bank(b_cmd_bank),
    .cmd_row(b_cmd_row), .cmd_col(b_cmd_col)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_a(input logic w, input logic rk, input logic [1:0] bg,
                        input logic [1:0] bk, input logic [15:0] row, input logic [9:0] col);
    a_write = w; a_rank = rk; a_bg = bg; a_bank = bk; a_row = row; a_col = col;
    a_valid = 1'b1;
  endtask

  task automatic send_b(input logic [15:0] row, input logic [9:0] col);
    b_write = 1'b0; b_rank = 1'b0; b_bg = 2'd0; b_bank = 2'd3; b_row = row; b_col = col;
    b_valid = 1'b1;
  endtask

  task automatic wait_ready_a(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (a_ready) break;
      tick();
    end
    if (i == budget) check(tag, 32'(a_ready), 32'd1);
  endtask

  task automatic wait_ack_a(input string tag, input int start, input int budget, input int exp_cyc);
    int cyc;
    int ack_cyc;
    cyc = start;
    ack_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      cyc++;
      if (a_ref_ack) begin
        ack_cyc = cyc;
        a_ref_req = 1'b0;
        break;
      end
    end
    a_ref_req = 1'b0;
    check(tag, 32'(ack_cyc), 32'(exp_cyc));
  endtask

  initial begin
    RST = 1'b1;
    a_valid = 0; a_write = 0; a_rank = 0; a_bg = 0; a_bank = 0; a_row = 0; a_col = 0; a_ref_req = 0;
    b_valid = 0; b_write = 0; b_rank = 0; b_bg = 0; b_bank = 0; b_row = 0; b_col = 0; b_ref_req = 0;
    tick();
    tick();
    check("rst_cmd_valid", 32'(a_cmd_valid), 32'd0);
    check("rst_cmd", 32'(a_cmd), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_ref_ack", 32'(a_ref_ack), 32'd0);
    check("rst_cmd_row", 32'(a_cmd_row), 32'd0);
    RST = 1'b0;
    #1;
    check("idle_ready", 32'(a_ready), 32'd1);

    // Closed bank read: ACT at 1, RD at 5, ready again at 7
    send_a(1'b0, 1'b0, 2'd1, 2'd2, 16'h1234, 10'h010);
    tick();
    a_valid = 1'b0;
    check("closed_act_cmd", 32'(a_cmd), 32'd1);
    check("closed_act_valid", 32'(a_cmd_valid), 32'd1);
    check("closed_act_row", 32'(a_cmd_row), 32'h1234);
    check("closed_act_bg", 32'(a_cmd_bg), 32'd1);
    check("closed_act_bank", 32'(a_cmd_bank), 32'd2);
    check("closed_act_col", 32'(a_cmd_col), 32'd0);
    tick();
    check("closed_wait_valid", 32'(a_cmd_valid), 32'd0);
    check("closed_wait_cmd", 32'(a_cmd), 32'd0);
    tick(); tick(); tick();
    check("closed_rd_cmd", 32'(a_cmd), 32'd2);
    check("closed_rd_col", 32'(a_cmd_col), 32'h010);
    check("closed_rd_row", 32'(a_cmd_row), 32'd0);
    tick();
    check("closed_ready_c6", 32'(a_ready), 32'd0);
    tick();
    check("closed_ready_c7", 32'(a_ready), 32'd1);

    // Row hit: RD next cycle, then write hit gives WR
    send_a(1'b0, 1'b0, 2'd1, 2'd2, 16'h1234, 10'h020);
    tick();
    a_valid = 1'b0;
    check("hit_rd_cmd", 32'(a_cmd), 32'd2);
    check("hit_rd_col", 32'(a_cmd_col), 32'h020);
    tick(); tick();
    check("hit_ready", 32'(a_ready), 32'd1);
    send_a(1'b1, 1'b0, 2'd1, 2'd2, 16'h1234, 10'h030);
    tick();
    a_valid = 1'b0;
    check("hit_wr_cmd", 32'(a_cmd), 32'd3);
    tick(); tick();

    // Row conflict: PRE at 1, ACT at 5, RD at 9
    send_a(1'b0, 1'b0, 2'd1, 2'd2, 16'h5678, 10'h040);
    tick();
    a_valid = 1'b0;
    check("conf_pre_cmd", 32'(a_cmd), 32'd4);
    check("conf_pre_bank", 32'(a_cmd_bank), 32'd2);
    check("conf_pre_row", 32'(a_cmd_row), 32'd0);
    tick(); tick(); tick(); tick();
    check("conf_act_cmd", 32'(a_cmd), 32'd1);
    check("conf_act_row", 32'(a_cmd_row), 32'h5678);
    tick(); tick(); tick(); tick();
    check("conf_rd_cmd", 32'(a_cmd), 32'd2);
    check("conf_rd_col", 32'(a_cmd_col), 32'h040);
    tick(); tick();
    check("conf_ready", 32'(a_ready), 32'd1);
    send_a(1'b0, 1'b0, 2'd1, 2'd2, 16'h5678, 10'h044);
    tick();
    a_valid = 1'b0;
    check("conf_table_hit", 32'(a_cmd), 32'd2);
    tick(); tick();

    // Refresh priority over a simultaneous request
    a_ref_req = 1'b1;
    send_a(1'b0, 1'b0, 2'd1, 2'd2, 16'h5678, 10'h048);
    #1;
    check("ref_ready_low", 32'(a_ready), 32'd0);
    tick();
    check("ref_prea_cmd", 32'(a_cmd), 32'd5);
    check("ref_prea_rank", 32'(a_cmd_rank), 32'd0);
    tick(); tick(); tick(); tick();
    check("ref_ref_cmd", 32'(a_cmd), 32'd6);
    wait_ack_a("ref_ack_cycle", 5, 40, 20);
    tick();
    check("ref_ack_pulse", 32'(a_ref_ack), 32'd0);
    check("ref_ready_back", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    check("ref_then_act", 32'(a_cmd), 32'd1);
    check("ref_then_act_row", 32'(a_cmd_row), 32'h5678);
    tick();
    wait_ready_a("ref_drain", 20);

    // Reset during WAIT_RCD, then the same request activates again
    send_a(1'b0, 1'b1, 2'd3, 2'd1, 16'hABCD, 10'h005);
    tick();
    a_valid = 1'b0;
    check("mid_act_cmd", 32'(a_cmd), 32'd1);
    check("mid_act_rank", 32'(a_cmd_rank), 32'd1);
    tick();
    RST = 1'b1;
    tick();
    check("mid_rst_valid", 32'(a_cmd_valid), 32'd0);
    check("mid_rst_cmd", 32'(a_cmd), 32'd0);
    check("mid_rst_row", 32'(a_cmd_row), 32'd0);
    check("mid_rst_rank", 32'(a_cmd_rank), 32'd0);
    check("mid_rst_ready", 32'(a_ready), 32'd0);
    RST = 1'b0;
    #1;
    check("mid_idle_ready", 32'(a_ready), 32'd1);
    send_a(1'b0, 1'b1, 2'd3, 2'd1, 16'hABCD, 10'h005);
    tick();
    a_valid = 1'b0;
    check("mid_reissue_act", 32'(a_cmd), 32'd1);
    check("mid_reissue_row", 32'(a_cmd_row), 32'hABCD);
    tick();
    wait_ready_a("mid_drain", 20);

    // PREA addresses the rank of the last accepted request
    a_ref_req = 1'b1;
    tick();
    check("prea_last_rank_cmd", 32'(a_cmd), 32'd5);
    check("prea_last_rank", 32'(a_cmd_rank), 32'd1);
    wait_ack_a("ref2_ack_cycle", 1, 40, 20);

    // All spacings at 1: closed then conflict run back to back
    send_b(16'h1111, 10'h001);
    tick();
    b_valid = 1'b0;
    check("b_act_cmd", 32'(b_cmd), 32'd1);
    tick();
    check("b_rd_cmd", 32'(b_cmd), 32'd2);
    tick();
    check("b_ready", 32'(b_ready), 32'd1);
    send_b(16'h2222, 10'h002);
    tick();
    b_valid = 1'b0;
    check("b_conf_pre", 32'(b_cmd), 32'd4);
    tick();
    check("b_conf_act", 32'(b_cmd), 32'd1);
    check("b_conf_act_row", 32'(b_cmd_row), 32'h2222);
    tick();
    check("b_conf_rd", 32'(b_cmd), 32'd2);
    check("b_conf_rd_valid", 32'(b_cmd_valid), 32'd1);
    tick();
    check("b_conf_ready", 32'(b_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_cmd_fsm.md
Name: dram_cmd_fsm

Overview:
- Command-generation stage directly downstream of the address mapper.
- Takes one decoded request at a time (rank, BG, bank, row, col, read/write) and emits the DRAM command sequence that services it: PRE, ACT, RD or WR.
- Tracks the open row of every bank and enforces tRP, tRCD and tCCD spacing.
- Also services a refresh request: PREA, then REF, then a tRFC wait.

Parameters:
- RANK_BITS, 1, rank field width
- BANK_GROUP_BITS, 2, bank-group field width
- BANK_BITS, 2, bank field width
- ROW_BITS, 16, row field width
- COLUMN_BITS, 10, column field width
- T_RP, 4, precharge to activate, cycles (1..255)
- T_RCD, 4, activate to RD/WR, cycles (1..255)
- T_CCD, 2, RD/WR to next accept spacing, cycles (1..255)
- T_RFC, 16, REF to refresh complete, cycles (1..255)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req_valid  in  1  decoded request present
- req_ready  out  1  block accepts request this cycle
- req_write  in  1  1=write, 0=read
- req_rank  in  RANK_BITS  from address mapper
- req_bg  in  BANK_GROUP_BITS  from address mapper
- req_bank  in  BANK_BITS  from address mapper
- req_row  in  ROW_BITS  from address mapper
- req_col  in  COLUMN_BITS  from address mapper
- ref_req  in  1  refresh needed (level, held until ref_ack)
- ref_ack  out  1  one-cycle pulse, refresh done
- cmd_valid  out  1  command on cmd_* this cycle
- cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF
- cmd_rank  out  RANK_BITS  target rank
- cmd_bg  out  BANK_GROUP_BITS  target bank group
- cmd_bank  out  BANK_BITS  target bank
- cmd_row  out  ROW_BITS  row (ACT only, else 0)
- cmd_col  out  COLUMN_BITS  column (RD/WR only, else 0)

Behaviour:
- Reset (any cycle, including mid-sequence):
  - state IDLE; every bank marked closed.
  - Outputs 0: cmd_valid, cmd=NOP, ref_ack, all cmd_* fields. The captured request is discarded.
  - req_ready is 0 while RST is high.
- Handshake:
  - req_ready = (state==IDLE) && !ref_req.
  - A request is accepted on a clock edge where req_valid && req_ready; all req_* fields are captured into a holding register at that edge.
  - req_* inputs are don't-care outside accepting cycles.
- Bank table: one entry {open, row} per {rank, BG, bank}, 2^(RANK_BITS+BANK_GROUP_BITS+BANK_BITS) entries, indexed by the captured request.
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, ISSUE, WAIT_CCD, REF_PREA, REF_WAIT_RP, REF, REF_WAIT_RFC.
- IDLE:
  - If ref_req is high, go to REF_PREA; refresh has priority over a simultaneous req_valid.
  - Else on accept, classify against the table:
    - hit (open, same row): go to ISSUE
    - closed: go to ACT
    - conflict (open, different row): go to PRE
- Command states (cmd_valid=1 for exactly one cycle in each):
  - PRE: cmd=PRE for the captured bank; entry marked closed; go to WAIT_RP.
  - ACT: cmd=ACT with the captured row; entry set {1,row}; go to WAIT_RCD.
  - ISSUE: cmd=RD or WR with the captured col; go to WAIT_CCD.
- Wait states: a down-counter loaded on entry; cmd_valid=0 and cmd=NOP while waiting.
  - WAIT_RP: T_RP-1 cycles.
  - WAIT_RCD: T_RCD-1 cycles.
  - WAIT_CCD: T_CCD-1 cycles.
  - A value of 1 gives zero wait cycles: go straight to the next state.
- Latency from the accept edge, cycle 0:
  - hit: RD/WR at 1
  - closed: ACT at 1, RD/WR at 1+T_RCD
  - conflict: PRE at 1, ACT at 1+T_RP, RD/WR at 1+T_RP+T_RCD
  - IDLE is re-entered T_CCD cycles after the RD/WR cycle.
- Refresh sequence:
  - REF_PREA: cmd=PREA (cmd_rank = the rank last used, 0 after reset); all entries closed.
  - REF_WAIT_RP: T_RP-1 cycles.
  - REF: cmd=REF.
  - REF_WAIT_RFC: T_RFC-1 cycles.
  - ref_ack=1 in the last REF_WAIT_RFC cycle (in the REF cycle itself if T_RFC=1), then IDLE.
  - A ref_req rising mid-request is deferred until IDLE; the request in flight always completes.
- cmd_* outputs are registered: no combinational path from req_* to cmd_*.

Test Plan:
- Closed bank: reset, then read rank0/BG1/bank2/row 0x1234/col 0x10 accepted at cycle 0 -> ACT row 0x1234 at 1; RD col 0x10 at 5; req_ready high again at 7.
- Row hit: a second read to the same bank, row 0x1234, col 0x20, accepted at 7 -> RD at 8, no ACT/PRE; write version gives cmd=3.
- Row conflict: same bank, row 0x5678, accepted at cycle 0 -> PRE at 1, ACT 0x5678 at 5, RD at 9; table now holds 0x5678.
- Refresh priority: ref_req and req_valid both high in IDLE at cycle 0 -> req_ready=0; PREA at 1, REF at 5, ref_ack pulse at 20. The next request to the previously open bank then issues ACT (closed), not a hit.
- Reset mid-sequence: assert RST in the WAIT_RCD cycle after ACT -> next cycle all outputs 0, state IDLE. The same request re-sent after reset issues ACT again.
- Parameter corners: T_RCD=1, T_RP=1, T_CCD=1 -> conflict issues PRE, ACT, RD on cycles 1, 2, 3 with no NOP gaps; req_ready high at 4.
